sad_topk_tracker: RTL
=====================

Name: sad_topk_tracker

Overview:
Sequential successor to the single-entry minimum-SAD register in the motion-estimation datapath.
- Consumes one streamed SAD candidate per cycle (SAD value plus search-window row/column).
- Keeps the TOP_K smallest candidates, sorted ascending, across one search window delimited by Start and Last.
- Presents the sorted list and a Done pulse to the motion-vector selection stage.

Parameters:
SAD_W, 32, width of SAD values
COORD_W, 8, width of row and column coordinates
TOP_K, 4, number of best candidates retained (legal range 1..8)

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  asynchronous active-high reset
Start  in  1  opens a new search window and clears the list
Valid  in  1  candidate present on SADIn/RowIn/ColumnIn this cycle
Last  in  1  qualifies Valid; final candidate of the window
SADIn  in  SAD_W  candidate SAD
RowIn  in  COORD_W  candidate row
ColumnIn  in  COORD_W  candidate column
Busy  out  1  high while in ACCUM state
Done  out  1  one-cycle pulse; list is final
Count  out  4  number of occupied entries, 0..TOP_K
MinSADOut  out  TOP_K*SAD_W  sorted SADs; entry 0 in LSBs is the smallest
MinSADRowOut  out  TOP_K*COORD_W  rows matching MinSADOut
MinSADColumnOut  out  TOP_K*COORD_W  columns matching MinSADOut

Behaviour:
- Reset, asynchronous with Rst high:
  - state returns to IDLE.
  - Busy=0, Done=0, Count=0.
  - Every SAD entry is set to all-ones; every row and column entry is set to 0.
  - Rst asserted mid-window discards the window immediately.
- States and transitions:
  - IDLE: Start -> ACCUM. Valid without Start is ignored.
  - ACCUM: accepted Valid&Last -> DONE. Start -> ACCUM (restart).
  - DONE: lasts exactly one cycle with Done=1, then -> IDLE. Start in this cycle -> ACCUM.
- Start:
  - clears all entries to the reset values and sets Count=0 on the same edge.
  - if Valid is also high in that cycle, the candidate is inserted into the freshly cleared list as the window's first candidate. If Last is high too, the window ends with Count=1.
  - Start during ACCUM abandons the current window without a Done pulse.
- Insertion, on a Valid cycle in ACCUM or with Start:
  - p = number of entries whose SAD is <= SADIn. The comparison counts occupied entries only.
  - entries p..TOP_K-2 shift up by one; entry p takes the candidate.
  - the old entry TOP_K-1 is dropped.
  - if p == TOP_K, the candidate is discarded.
- Tie rule: a candidate equal to a held SAD is placed after it, so the earlier arrival wins. This matches the strict less-than replacement of the single-entry design.
- Count increments on each insertion and saturates at TOP_K.
- Latency: list and Count update on the edge that accepts the candidate. Done rises on the edge after the Last candidate is accepted.
- After Done the outputs hold until the next Start or Rst.
- Comparisons are unsigned at full SAD_W; there is no overflow or saturation logic.
- Pipelining: one compare stage with parallel comparators plus a priority encode for p. Sustained throughput is one candidate per cycle with no stalls.

Optional Feature:
Macro SAD_EARLY_EXIT_EN.
- Defined:
  - adds input Threshold (SAD_W) and output EarlyExit (1).
  - EarlyExit is registered. It is set on the edge where an accepted candidate has SADIn <= Threshold. It is cleared by Start or Rst.
  - When it is set, the block moves to DONE on the next edge even without Last. Further Valid inputs in that window are ignored until Start.
- Not defined: neither port exists. A window ends only on Last.

Test Plan:
- TOP_K=4. Rst, then Start with stream SAD 50,20,70,20,10 (Last on 10) -> sorted 10,20,20,50. The first 20 has the earlier coordinates. Count=4. Done pulses one cycle after 10.
- Start, then a single candidate SAD 5 at (3,7) with Start, Valid and Last in the same cycle -> Count=1, entry0=5/(3,7), entries 1..3 all-ones. Done on the next edge.
- Start with 10 accepted candidates all SAD 0xFFFFFFFF -> Count=4. Entries hold the first four candidates' coordinates. Later candidates are discarded.
- Mid-window Start after 3 candidates -> no Done pulse. The list is cleared and the new window's results exclude the old candidates.
- Rst asserted asynchronously between clock edges during ACCUM -> outputs reach reset values before the next edge. Busy=0.
- SAD_EARLY_EXIT_EN defined, Threshold=15: stream 40,12,3 -> EarlyExit=1 after 12. Done on the next edge. The 3 is ignored and the list is 12,40.

Source files
------------

// File: rtl/sad_topk_tracker.sv
// sad_topk_tracker: keeps the TOP_K smallest SAD candidates of a search window, sorted ascending.
// Build option SAD_EARLY_EXIT_EN adds Threshold/EarlyExit so a good-enough match closes the window.
module sad_topk_tracker #(
  parameter int SAD_W   = 32,
  parameter int COORD_W = 8,
  parameter int TOP_K   = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic                     Valid,
  input  logic                     Last,
  input  logic [SAD_W-1:0]         SADIn,
  input  logic [COORD_W-1:0]       RowIn,
  input  logic [COORD_W-1:0]       ColumnIn,
`ifdef SAD_EARLY_EXIT_EN
  input  logic [SAD_W-1:0]         Threshold,
  output logic                     EarlyExit,
`endif
  output logic                     Busy,
  output logic                     Done,
  output logic [3:0]               Count,
  output logic [TOP_K*SAD_W-1:0]   MinSADOut,
  output logic [TOP_K*COORD_W-1:0] MinSADRowOut,
  output logic [TOP_K*COORD_W-1:0] MinSADColumnOut
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] K_CNT   = 4'(TOP_K);

  logic [1:0]         state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic               exit_q, exit_d;
  logic [SAD_W-1:0]   sad_q [TOP_K];
  logic [SAD_W-1:0]   sad_d [TOP_K];
  logic [COORD_W-1:0] row_q [TOP_K];
  logic [COORD_W-1:0] row_d [TOP_K];
  logic [COORD_W-1:0] col_q [TOP_K];
  logic [COORD_W-1:0] col_d [TOP_K];

  logic [SAD_W-1:0]   base_sad [TOP_K];
  logic [COORD_W-1:0] base_row [TOP_K];
  logic [COORD_W-1:0] base_col [TOP_K];
  logic [SAD_W-1:0]   sh_sad [TOP_K];
  logic [COORD_W-1:0] sh_row [TOP_K];
  logic [COORD_W-1:0] sh_col [TOP_K];
  logic [3:0]         base_cnt;
  logic [TOP_K-1:0]   le;
  logic [3:0]         pos;
  logic               accept, insert, hit;

`ifdef SAD_EARLY_EXIT_EN
  assign hit       = (SADIn <= Threshold);
  assign EarlyExit = exit_q;
`else
  assign hit = 1'b0;
`endif

  // Start presents a freshly cleared list, so a same-cycle candidate lands in an empty window
  always_comb begin
    accept   = Valid && (Start || (state_q == S_ACCUM && !exit_q));
    base_cnt = Start ? 4'd0 : count_q;
    for (int i = 0; i < TOP_K; i++) begin
      base_sad[i] = Start ? '1 : sad_q[i];
      base_row[i] = Start ? '0 : row_q[i];
      base_col[i] = Start ? '0 : col_q[i];
      le[i]       = (4'(i) < base_cnt) && (base_sad[i] <= SADIn);
    end
    // list is sorted, so le is a thermometer code; the first zero is the insert slot
    pos = K_CNT;
    for (int i = TOP_K - 1; i >= 0; i--) begin
      if (!le[i]) pos = 4'(i);
    end
    insert = accept && (pos < K_CNT);
  end

  always_comb begin
    sh_sad[0] = SADIn;
    sh_row[0] = RowIn;
    sh_col[0] = ColumnIn;
    for (int i = 1; i < TOP_K; i++) begin
      sh_sad[i] = base_sad[i-1];
      sh_row[i] = base_row[i-1];
      sh_col[i] = base_col[i-1];
    end
    for (int i = 0; i < TOP_K; i++) begin
      sad_d[i] = base_sad[i];
      row_d[i] = base_row[i];
      col_d[i] = base_col[i];
      if (insert && 4'(i) == pos) begin
        sad_d[i] = SADIn;
        row_d[i] = RowIn;
        col_d[i] = ColumnIn;
      end else if (insert && 4'(i) > pos) begin
        sad_d[i] = sh_sad[i];
        row_d[i] = sh_row[i];
        col_d[i] = sh_col[i];
      end
    end
    count_d = base_cnt;
    if (insert && base_cnt != K_CNT) count_d = base_cnt + 4'd1;
    exit_d = Start ? (accept && hit) : (exit_q || (accept && hit));
    state_d = state_q;
    if (Start) begin
      state_d = (accept && Last) ? S_DONE : S_ACCUM;
    end else begin
      case (state_q)
        S_ACCUM: if (exit_q || (accept && Last)) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      exit_q  <= 1'b0;
      for (int i = 0; i < TOP_K; i++) begin
        sad_q[i] <= '1;
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      exit_q  <= exit_d;
      for (int i = 0; i < TOP_K; i++) begin
        sad_q[i] <= sad_d[i];
        row_q[i] <= row_d[i];
        col_q[i] <= col_d[i];
      end
    end
  end

  assign Busy  = (state_q == S_ACCUM);
  assign Done  = (state_q == S_DONE);
  assign Count = count_q;

  for (genvar g = 0; g < TOP_K; g++) begin : g_pack
    assign MinSADOut[g*SAD_W +: SAD_W]         = sad_q[g];
    assign MinSADRowOut[g*COORD_W +: COORD_W]    = row_q[g];
    assign MinSADColumnOut[g*COORD_W +: COORD_W] = col_q[g];
  end

endmodule
